// File: rtl/signal_gen_pkg.sv
// Constants and FSM state encoding shared by signal_generator and signal_checker.
package signal_gen_pkg;

  localparam logic [7:0] DEFAULT_DATA_CHAR_PATTERN = 8'hAA;
  localparam logic [7:0] DEFAULT_CTRL_CHAR_PATTERN = 8'h55;

  typedef logic [0:0] state_t;
  localparam state_t UNLOCKED = 1'b0;
  localparam state_t LOCKED   = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating accumulator with a synchronous clear that takes priority over the increment.
module sat_counter
  import signal_gen_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int INC_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 en,
  input  logic [INC_WIDTH-1:0] inc,
  output logic [WIDTH-1:0]     count
);

  localparam int SUM_W = WIDTH + 1;

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH:0]   sum;

  // One spare bit catches the wrap so the result can be pinned at all-ones.
  always_comb sum = {1'b0, count_reg} + SUM_W'(inc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/signal_checker.sv
// Two-stage octet-pattern checker with lock FSM and optional statistics.
// Statistics counters are built only when SIGNAL_CHECKER_STATS_EN is defined.
module signal_checker
  import signal_gen_pkg::*;
#(
  parameter int         DATA_WIDTH        = 64,
  parameter int         CTRL_WIDTH        = DATA_WIDTH / 8,
  parameter logic [7:0] DATA_CHAR_PATTERN = DEFAULT_DATA_CHAR_PATTERN,
  parameter logic [7:0] CTRL_CHAR_PATTERN = DEFAULT_CTRL_CHAR_PATTERN,
  parameter int         LOCK_COUNT        = 4,
  parameter int         UNLOCK_COUNT      = 2,
  parameter int         CNT_WIDTH         = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [CTRL_WIDTH-1:0] i_ctrl,
  input  logic                  i_clear,
  output logic [CTRL_WIDTH-1:0] o_err_lanes,
  output logic                  o_err,
  output logic                  o_lock,
  output logic [CNT_WIDTH-1:0]  o_data_cnt,
  output logic [CNT_WIDTH-1:0]  o_ctrl_cnt,
  output logic [CNT_WIDTH-1:0]  o_err_cnt
);

  localparam int RUN_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);

  // ---------------- stage 1: per-lane compare ----------------
  logic [CTRL_WIDTH-1:0] lane_err;
  logic [CTRL_WIDTH-1:0] err_lanes_reg;
  logic                  valid_reg;

  generate
    for (genvar gi = 0; gi < CTRL_WIDTH; gi++) begin : g_lane
      assign lane_err[gi] = i_data[8*gi +: 8] !=
                            (i_ctrl[gi] ? CTRL_CHAR_PATTERN : DATA_CHAR_PATTERN);
    end
  endgenerate

  // valid_reg keeps the reset-cleared stage-1 register from posing as a clean word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_lanes_reg <= '0;
      valid_reg     <= 1'b0;
    end else begin
      err_lanes_reg <= lane_err;
      valid_reg     <= 1'b1;
    end
  end

  assign o_err_lanes = err_lanes_reg;
  assign o_err       = |err_lanes_reg;

  // ---------------- stage 2: lock FSM ----------------
  state_t           state_reg, state_next;
  logic [RUN_W-1:0] clean_run_reg, clean_run_next;
  logic [RUN_W-1:0] err_run_reg, err_run_next;
  logic             word_err;

  assign word_err = |err_lanes_reg;

  always_comb begin
    state_next     = state_reg;
    clean_run_next = clean_run_reg;
    err_run_next   = err_run_reg;
    if (valid_reg) begin
      if (state_reg == UNLOCKED) begin
        if (word_err) begin
          clean_run_next = '0;
        end else if (clean_run_reg == RUN_W'(LOCK_COUNT - 1)) begin
          state_next     = LOCKED;
          clean_run_next = '0;
          err_run_next   = '0;
        end else begin
          clean_run_next = clean_run_reg + 1'b1;
        end
      end else begin
        if (!word_err) begin
          err_run_next = '0;
        end else if (err_run_reg == RUN_W'(UNLOCK_COUNT - 1)) begin
          state_next     = UNLOCKED;
          clean_run_next = '0;
          err_run_next   = '0;
        end else begin
          err_run_next = err_run_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= UNLOCKED;
      clean_run_reg <= '0;
      err_run_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      clean_run_reg <= clean_run_next;
      err_run_reg   <= err_run_next;
    end
  end

  assign o_lock = (state_reg == LOCKED);

  // ---------------- stage 2: statistics ----------------
`ifdef SIGNAL_CHECKER_STATS_EN
  localparam int PW = $clog2(CTRL_WIDTH + 1);

  logic [CTRL_WIDTH-1:0] ctrl_reg;
  logic [PW-1:0]         ctrl_ones;
  logic [PW-1:0]         data_ones;
  logic [PW-1:0]         err_ones;
  logic                  count_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_reg <= '0;
    end else begin
      ctrl_reg <= i_ctrl;
    end
  end

  always_comb begin
    ctrl_ones = '0;
    err_ones  = '0;
    for (int k = 0; k < CTRL_WIDTH; k++) begin
      ctrl_ones = ctrl_ones + PW'(ctrl_reg[k]);
      err_ones  = err_ones + PW'(err_lanes_reg[k]);
    end
    data_ones = PW'(CTRL_WIDTH) - ctrl_ones;
  end

  // The word that drops the lock is still counted because state_reg is LOCKED while it is evaluated.
  assign count_en = valid_reg && (state_reg == LOCKED);

  sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(PW)) u_data_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (i_clear),
    .en    (count_en),
    .inc   (data_ones),
    .count (o_data_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(PW)) u_ctrl_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (i_clear),
    .en    (count_en),
    .inc   (ctrl_ones),
    .count (o_ctrl_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(PW)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (i_clear),
    .en    (count_en),
    .inc   (err_ones),
    .count (o_err_cnt)
  );
`else
  logic unused_clear;

  assign unused_clear = i_clear;
  assign o_data_cnt   = '0;
  assign o_ctrl_cnt   = '0;
  assign o_err_cnt    = '0;
`endif

endmodule

// File: tb/tb_signal_checker.sv
// Scoreboard bench for signal_checker (CNT_WIDTH=8 so saturation is reachable).
module tb_signal_checker;

  localparam int DW    = 64;
  localparam int CW    = 8;
  localparam int CNT_W = 8;
  localparam int LOCK_N   = 4;
  localparam int UNLOCK_N = 2;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef SIGNAL_CHECKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [63:0] CLEAN     = {8{8'hAA}};
  localparam logic [63:0] ALL_BAD   = 64'h0;
  localparam logic [63:0] LANE3_BAD = 64'hAAAAAAAA_00AAAAAA;
  localparam logic [63:0] MIXED     = 64'hAAAAAAAA_55555555;

  logic             clk;
  logic             rst;
  logic [DW-1:0]    i_data;
  logic [CW-1:0]    i_ctrl;
  logic             i_clear;
  logic [CW-1:0]    o_err_lanes;
  logic             o_err;
  logic             o_lock;
  logic [CNT_W-1:0] o_data_cnt;
  logic [CNT_W-1:0] o_ctrl_cnt;
  logic [CNT_W-1:0] o_err_cnt;

  signal_checker #(
    .DATA_WIDTH   (DW),
    .CTRL_WIDTH   (CW),
    .LOCK_COUNT   (LOCK_N),
    .UNLOCK_COUNT (UNLOCK_N),
    .CNT_WIDTH    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_data      (i_data),
    .i_ctrl      (i_ctrl),
    .i_clear     (i_clear),
    .o_err_lanes (o_err_lanes),
    .o_err       (o_err),
    .o_lock      (o_lock),
    .o_data_cnt  (o_data_cnt),
    .o_ctrl_cnt  (o_ctrl_cnt),
    .o_err_cnt   (o_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] err;
    logic [7:0] ctrl;
  } sb_item_t;

  sb_item_t sb_q[$];
  sb_item_t s2_item;
  bit       s2_valid;

  int n_vectors;
  int n_miscompares;
  int n_words;

  // Reference model state for stage 2
  bit          m_lock;
  int          m_clean_run;
  int          m_err_run;
  int unsigned m_data_cnt;
  int unsigned m_ctrl_cnt;
  int unsigned m_err_cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b);
    int unsigned s;
    s = a + b;
    return (s > CNT_MAX) ? CNT_MAX : s;
  endfunction

  function automatic logic [7:0] expect_err(input logic [63:0] d, input logic [7:0] c);
    logic [7:0] e;
    logic [7:0] want;
    for (int k = 0; k < CW; k++) begin
      want = c[k] ? 8'h55 : 8'hAA;
      e[k] = (d[8*k +: 8] != want);
    end
    return e;
  endfunction

  task automatic model_reset();
    m_lock      = 1'b0;
    m_clean_run = 0;
    m_err_run   = 0;
    m_data_cnt  = 0;
    m_ctrl_cnt  = 0;
    m_err_cnt   = 0;
    s2_valid    = 1'b0;
    sb_q.delete();
  endtask

  // Evaluates the word captured by stage 1 on the previous edge, as seen at this edge.
  task automatic model_stage2(input logic clr);
    int nc;
    int ne;
    bit werr;
    if (s2_valid) begin
      werr = |s2_item.err;
      if (m_lock) begin
        nc = $countones(s2_item.ctrl);
        ne = $countones(s2_item.err);
        m_ctrl_cnt = sat_add(m_ctrl_cnt, nc);
        m_data_cnt = sat_add(m_data_cnt, CW - nc);
        m_err_cnt  = sat_add(m_err_cnt, ne);
        if (!werr) m_err_run = 0;
        else begin
          m_err_run++;
          if (m_err_run == UNLOCK_N) begin
            m_lock = 1'b0; m_clean_run = 0; m_err_run = 0;
          end
        end
      end else begin
        if (werr) m_clean_run = 0;
        else begin
          m_clean_run++;
          if (m_clean_run == LOCK_N) begin
            m_lock = 1'b1; m_clean_run = 0; m_err_run = 0;
          end
        end
      end
    end
    if (clr) begin
      m_data_cnt = 0;
      m_ctrl_cnt = 0;
      m_err_cnt  = 0;
    end
  endtask

  task automatic step(input logic [63:0] d, input logic [7:0] c, input logic clr);
    sb_item_t it;
    sb_item_t cur;
    i_data  = d;
    i_ctrl  = c;
    i_clear = clr;
    it.err  = expect_err(d, c);
    it.ctrl = c;
    sb_q.push_back(it);
    @(posedge clk);
    #1;
    model_stage2(clr);
    cur = sb_q.pop_front();
    s2_item  = cur;
    s2_valid = 1'b1;
    n_words++;
    $display("word %0d data=%h ctrl=%h clr=%0d err_lanes=%h lock=%0d data_cnt=%0d ctrl_cnt=%0d err_cnt=%0d",
             n_words, d, c, clr, o_err_lanes, o_lock, o_data_cnt, o_ctrl_cnt, o_err_cnt);
    check_eq("err_lanes", o_err_lanes, cur.err);
    check_eq("err", o_err, |cur.err);
    check_eq("lock", o_lock, m_lock);
    check_eq("data_cnt", o_data_cnt, STATS ? m_data_cnt : 0);
    check_eq("ctrl_cnt", o_ctrl_cnt, STATS ? m_ctrl_cnt : 0);
    check_eq("err_cnt", o_err_cnt, STATS ? m_err_cnt : 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_err_lanes"}, o_err_lanes, 0);
    check_eq({tag, "_err"}, o_err, 0);
    check_eq({tag, "_lock"}, o_lock, 0);
    check_eq({tag, "_data_cnt"}, o_data_cnt, 0);
    check_eq({tag, "_ctrl_cnt"}, o_ctrl_cnt, 0);
    check_eq({tag, "_err_cnt"}, o_err_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vectors     = 0;
    n_miscompares = 0;
    n_words       = 0;
    rst     = 1'b0;
    i_data  = '0;
    i_ctrl  = '0;
    i_clear = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;

    // Lock after four clean words, visible two cycles after the fourth
    for (int i = 0; i < 4; i++) step(CLEAN, 8'h00, 1'b0);
    check_eq("lock_not_early", o_lock, 0);
    step(CLEAN, 8'h00, 1'b0);
    check_eq("lock_after_4", o_lock, 1);
    check_eq("data_cnt_at_lock", o_data_cnt, 0);

    // Single errored lane while locked
    step(LANE3_BAD, 8'h00, 1'b0);
    check_eq("lane3_err_lanes", o_err_lanes, 8'h08);
    step(CLEAN, 8'h00, 1'b0);
    check_eq("lane3_err_cnt", o_err_cnt, STATS ? 1 : 0);
    check_eq("lane3_lock_held", o_lock, 1);

    // Two fully errored words drop the lock
    step(CLEAN, 8'h00, 1'b1);
    step(ALL_BAD, 8'h00, 1'b0);
    step(ALL_BAD, 8'h00, 1'b0);
    check_eq("unlock_not_early", o_lock, 1);
    step(CLEAN, 8'h00, 1'b0);
    check_eq("unlock_after_2", o_lock, 0);
    check_eq("unlock_err_cnt", o_err_cnt, STATS ? 16 : 0);

    repeat (5) step(CLEAN, 8'h00, 1'b0);
    check_eq("relock", o_lock, 1);

    // Mixed control/data lanes; clear lands with a pending increment on the first word
    step(MIXED, 8'h0F, 1'b1);
    repeat (9) step(MIXED, 8'h0F, 1'b0);
    step(CLEAN, 8'h00, 1'b0);
    check_eq("mixed_ctrl_cnt", o_ctrl_cnt, STATS ? 40 : 0);
    check_eq("mixed_data_cnt", o_data_cnt, STATS ? 40 : 0);

    // Saturation, then clear racing an increment
    repeat (40) step(CLEAN, 8'h00, 1'b0);
    check_eq("sat_data_cnt", o_data_cnt, STATS ? 255 : 0);
    step(CLEAN, 8'h00, 1'b0);
    check_eq("sat_hold", o_data_cnt, STATS ? 255 : 0);
    step(CLEAN, 8'h00, 1'b1);
    check_eq("clear_wins", o_data_cnt, 0);
    step(CLEAN, 8'h00, 1'b0);
    check_eq("count_after_clear", o_data_cnt, STATS ? 8 : 0);

    // Asynchronous reset while locked, then a full relock from scratch
    check_eq("pre_reset_lock", o_lock, 1);
    rst = 1'b0;
    #2;
    check_all_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    check_all_zero("rst_held");
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step(CLEAN, 8'h00, 1'b0);
    check_eq("post_rst_not_early", o_lock, 0);
    step(CLEAN, 8'h00, 1'b0);
    check_eq("post_rst_relock", o_lock, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
